// File: rtl/rv32i_shift_mul_engine.sv
// Multicycle SLL/SRL/SRA engine for the execute stage.
// Sub-chunk shifts use a shared narrow multiplier; whole-chunk moves are local.
module rv32i_shift_mul_engine #(
    parameter  int XLEN  = 32,
    parameter  int MUL_W = 16,
    localparam int SHW   = $clog2(XLEN)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_op,
    input  logic [XLEN-1:0]    i_operand_one,
    input  logic [XLEN-1:0]    i_operand_two,
    output logic               o_valid,
    output logic [XLEN-1:0]    o_result,
    output logic               o_mul_req,
    output logic [MUL_W-1:0]   o_mul_operand_one,
    output logic [MUL_W-1:0]   o_mul_operand_two,
    input  logic               i_mul_ack,
    input  logic [2*MUL_W-1:0] i_mul_result
);

    localparam int N  = XLEN / MUL_W;
    localparam int RW = $clog2(MUL_W);
    localparam int KW = $clog2(N + 2);
    // Products land at chunk k of a wide accumulator; N+2 chunks cover p_N's high half.
    localparam int AW = (N + 2) * MUL_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [SHW-1:0]    shamt_q, shamt_d;
    logic [KW-1:0]     k_q, k_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              valid_q, valid_d;

    logic                   right;
    logic                   sra;
    logic [RW-1:0]          r;
    logic [RW:0]            amt;
    logic [MUL_W-1:0]       factor;
    logic [(N+1)*MUL_W-1:0] ext;
    logic [MUL_W-1:0]       chunk;
    logic                   last;
    logic                   unused_ok;

    // Whole-chunk move: shift by q*MUL_W, i.e. the shift amount with its low bits cleared.
    function automatic logic [XLEN-1:0] chunk_move(
        input logic [XLEN-1:0] a,
        input logic [1:0]      op,
        input logic [SHW-1:0]  sh
    );
        logic [SHW-1:0] m;
        m = sh & ~SHW'(MUL_W - 1);
        case (op)
            2'b00:   return a << m;
            2'b01:   return a >> m;
            2'b11:   return $signed(a) >>> m;
            default: return '0;
        endcase
    endfunction

    assign unused_ok = ^i_operand_two[XLEN-1:SHW];

    assign right  = op_q[0];
    assign sra    = (op_q == 2'b11);
    assign r      = shamt_q[RW-1:0];
    // Right shifts use 2^(MUL_W-r); r is never 0 here, so the factor never wraps.
    assign amt    = right ? (RW+1)'(MUL_W) - {1'b0, r} : {1'b0, r};
    assign factor = MUL_W'(1) << amt;
    assign ext    = {{MUL_W{sra & opnd_q[XLEN-1]}}, opnd_q};
    assign chunk  = ext[int'(k_q) * MUL_W +: MUL_W];
    assign last   = (k_q == KW'(right ? N : N - 1));

    assign o_ready  = (state_q == S_IDLE) && !valid_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;

    // Next-state, multiplier handshake and product merge.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        shamt_d  = shamt_q;
        k_d      = k_q;
        acc_d    = acc_q;
        result_d = result_q;
        valid_d  = 1'b0;

        o_mul_req         = 1'b0;
        o_mul_operand_one = '0;
        o_mul_operand_two = '0;

        case (state_q)
            S_IDLE: begin
                if (i_valid && o_ready) begin
                    op_d    = i_op;
                    opnd_d  = i_operand_one;
                    shamt_d = i_operand_two[SHW-1:0];
                    k_d     = '0;
                    acc_d   = '0;
                    if (i_op != 2'b10 && i_operand_two[RW-1:0] != '0) begin
                        state_d = S_MUL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                o_mul_req         = 1'b1;
                o_mul_operand_one = chunk;
                o_mul_operand_two = factor;
                if (i_mul_ack) begin
                    acc_d = acc_q | (AW'(i_mul_result) << (int'(k_q) * MUL_W));
                    k_d   = k_q + KW'(1);
                    if (last) begin
                        result_d = chunk_move(
                            right ? acc_d[XLEN+MUL_W-1:MUL_W] : acc_d[XLEN-1:0],
                            op_q, shamt_q);
                        valid_d  = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                result_d = chunk_move(opnd_q, op_q, shamt_q);
                valid_d  = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            opnd_q   <= '0;
            shamt_q  <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            shamt_q  <= shamt_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_rv32i_shift_mul_engine.sv
// Self-checking bench for rv32i_shift_mul_engine (XLEN=32, MUL_W=16).
// Multiplier responder with configurable wait states; shifts checked against plain operators.
module tb_rv32i_shift_mul_engine;

    localparam int XLEN  = 32;
    localparam int MUL_W = 16;
    localparam int N     = XLEN / MUL_W;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [31:0] i_operand_one;
    logic [31:0] i_operand_two;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_mul_req;
    logic [15:0] o_mul_operand_one;
    logic [15:0] o_mul_operand_two;
    logic        i_mul_ack;
    logic [31:0] i_mul_result;

    rv32i_shift_mul_engine #(.XLEN(XLEN), .MUL_W(MUL_W)) dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_op              (i_op),
        .i_operand_one     (i_operand_one),
        .i_operand_two     (i_operand_two),
        .o_valid           (o_valid),
        .o_result          (o_result),
        .o_mul_req         (o_mul_req),
        .o_mul_operand_one (o_mul_operand_one),
        .o_mul_operand_two (o_mul_operand_two),
        .i_mul_ack         (i_mul_ack),
        .i_mul_result      (i_mul_result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Multiplier model: acks after mul_wait idle cycles of a held request.
    int          mul_wait = 0;
    int          wcnt = 0;
    int          n_txn = 0;
    logic        inject = 1'b0;
    logic [15:0] hold_a, hold_b;
    logic [15:0] req_a[$];
    logic [15:0] req_b[$];

    always @(negedge clk) begin
        i_mul_ack    = 1'b0;
        i_mul_result = '0;
        if (inject) begin
            i_mul_ack    = 1'b1;
            i_mul_result = $urandom;
        end else if (o_mul_req && !i_rst) begin
            if (wcnt > 0) begin
                chk("req_stable_op1", 32'(o_mul_operand_one), 32'(hold_a));
                chk("req_stable_op2", 32'(o_mul_operand_two), 32'(hold_b));
            end
            hold_a = o_mul_operand_one;
            hold_b = o_mul_operand_two;
            if (wcnt >= mul_wait) begin
                i_mul_ack    = 1'b1;
                i_mul_result = 32'(o_mul_operand_one) * 32'(o_mul_operand_two);
                req_a.push_back(o_mul_operand_one);
                req_b.push_back(o_mul_operand_two);
                n_txn++;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    function automatic logic [31:0] ref_shift(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [4:0] s);
        case (op)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b11:   return $signed(a) >>> s;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_txn(input logic [1:0] op, input logic [4:0] s);
        if (op == 2'b10 || (s % MUL_W) == 0) return 0;
        return (op == 2'b00) ? N : N + 1;
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [4:0] s, input int w);
        int m;
        m = ref_txn(op, s);
        if (m == 0) return 2;
        return 1 + m + m * w;
    endfunction

    // Issue one request at a negedge and follow it to its o_valid pulse.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [4:0] s, input int w, input bit poke);
        logic [31:0] exp_res;
        int          exp_m;
        int          cyc;
        int          seen_req;
        int          b;
        exp_res  = ref_shift(op, a, s);
        exp_m    = ref_txn(op, s);
        b = 0;
        while (!o_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
        req_a.delete();
        req_b.delete();
        n_txn    = 0;
        mul_wait = w;
        i_valid       = 1'b1;
        i_op          = op;
        i_operand_one = a;
        i_operand_two = {$urandom_range(0, 134217727), s};
        @(negedge clk);
        cyc      = 1;
        seen_req = 0;
        i_valid       = poke;
        i_op          = 2'($urandom);
        i_operand_one = $urandom;
        i_operand_two = $urandom;
        chk("busy_after_accept", 32'(o_ready), 32'd0);
        chk("first_req", 32'(o_mul_req), 32'(exp_m > 0));
        while (!o_valid && cyc < 300) begin
            if (o_mul_req) seen_req++;
            @(negedge clk);
            cyc++;
            if (!o_valid && poke) begin
                i_valid       = 1'b1;
                i_op          = 2'($urandom);
                i_operand_one = $urandom;
                i_operand_two = $urandom;
            end
        end
        i_valid = 1'b0;
        if (!o_valid) chk("valid_timeout", 32'(o_valid), 32'd1);
        chk("result", o_result, exp_res);
        chk("latency", 32'(cyc), 32'(ref_lat(op, s, w)));
        chk("mul_txns", 32'(n_txn), 32'(exp_m));
        chk("req_cycles", 32'(seen_req), 32'(exp_m * (1 + w)));
        chk("ready_low_with_valid", 32'(o_ready), 32'd0);
        @(negedge clk);
        chk("valid_one_cycle", 32'(o_valid), 32'd0);
        chk("ready_back", 32'(o_ready), 32'd1);
        chk("result_held", o_result, exp_res);
    endtask

    initial begin
        int b;
        logic [1:0] rop;
        i_rst         = 1'b1;
        i_valid       = 1'b0;
        i_op          = 2'b00;
        i_operand_one = '0;
        i_operand_two = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_result", o_result, 32'h0);
        chk("rst_mul_req", 32'(o_mul_req), 32'd0);
        chk("rst_mul_op1", 32'(o_mul_operand_one), 32'h0);
        chk("rst_mul_op2", 32'(o_mul_operand_two), 32'h0);
        i_rst = 1'b0;
        @(negedge clk);

        run_op(2'b00, 32'h0000_00FF, 5'd4, 0, 1'b0);
        chk("sll4_req0_op1", 32'(req_a[0]), 32'h00FF);
        chk("sll4_req0_op2", 32'(req_b[0]), 32'h0010);
        chk("sll4_req1_op1", 32'(req_a[1]), 32'h0000);
        chk("sll4_req1_op2", 32'(req_b[1]), 32'h0010);

        run_op(2'b11, 32'h8000_0000, 5'd20, 0, 1'b0);
        chk("sra20_req0_op1", 32'(req_a[0]), 32'h0000);
        chk("sra20_req1_op1", 32'(req_a[1]), 32'h8000);
        chk("sra20_req2_op1", 32'(req_a[2]), 32'hFFFF);
        chk("sra20_req2_op2", 32'(req_b[2]), 32'h1000);

        run_op(2'b01, 32'h1234_5678, 5'd16, 0, 1'b0);
        run_op(2'b11, 32'h8765_4321, 5'd16, 0, 1'b0);
        run_op(2'b00, 32'h0000_0001, 5'd31, 0, 1'b0);
        run_op(2'b01, 32'h8000_0000, 5'd31, 0, 1'b0);
        chk("srl31_factor", 32'(req_b[0]), 32'h0002);
        run_op(2'b11, 32'h8000_0000, 5'd31, 1, 1'b0);
        run_op(2'b00, 32'hCAFE_F00D, 5'd0, 0, 1'b0);

        run_op(2'b00, 32'hDEAD_BEEF, 5'd8, 3, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("no_queued_req", 32'(o_valid), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            run_op(rop, $urandom, 5'($urandom), $urandom_range(0, 2), 1'($urandom));
        end

        req_a.delete();
        n_txn    = 0;
        mul_wait = 1;
        i_valid       = 1'b1;
        i_op          = 2'b01;
        i_operand_one = 32'hF0F0_1234;
        i_operand_two = 32'd5;
        @(negedge clk);
        i_valid = 1'b0;
        b = 0;
        while (n_txn < 1 && b < 20) begin
            @(negedge clk);
            #1;
            b++;
        end
        chk("abort_first_ack", 32'(n_txn), 32'd1);
        @(negedge clk);
        #1;
        i_rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_ready", 32'(o_ready), 32'd1);
        chk("abort_mul_req", 32'(o_mul_req), 32'd0);
        i_rst  = 1'b0;
        inject = 1'b1;
        @(negedge clk);
        #1;
        inject = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(o_valid), 32'd0);
            chk("abort_req_low", 32'(o_mul_req), 32'd0);
        end

        run_op(2'b10, 32'hFFFF_FFFF, 5'd7, 0, 1'b0);
        run_op(2'b10, $urandom, 5'($urandom), 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
